pipe_add_flow: RTL and testbench
================================

PIPE_ADD_FLOW -- requirements
Module: pipe_add_flow

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 1..64.
REQ-002 Parameter STAGES, default 2: number of register stages between input and output; legal range 1..8.
REQ-003 Parameter SAT_EN, default 0: 1 enables the saturating mode selected by mode_in; 0 forces wrap mode regardless of mode_in.
REQ-004 clk_in  input  1  single clock; all state updates on rising edge.
REQ-005 rst_in  input  1  reset; synchronous, active-high.
REQ-006 A_in  input  WIDTH  operand A, unsigned.
REQ-007 B_in  input  WIDTH  operand B, unsigned.
REQ-008 mode_in  input  1  0 = wrap, 1 = saturate; sampled with the operands.
REQ-009 valid_in  input  1  upstream offers A_in/B_in/mode_in this cycle.
REQ-010 ready_in  output  1  block accepts the offered operands this cycle.
REQ-011 Z_out  output  WIDTH  sum result.
REQ-012 carry_out  output  1  carry out of the raw WIDTH-bit add, for the result on Z_out.
REQ-013 sat_out  output  1  result was clamped, i.e. carry set and saturate mode active.
REQ-014 valid_out  output  1  Z_out/carry_out/sat_out hold a valid result.
REQ-015 ready_out  input  1  downstream accepts the result this cycle.
REQ-016 count_out  output  16  number of results delivered since reset; wraps at 65535 to 0.

Function
REQ-017 Input transfer occurs when valid_in and ready_in are both 1 in the same cycle. Output transfer occurs when valid_out and ready_out are both 1 in the same cycle.
REQ-018 Raw sum = A_in + B_in computed at WIDTH+1 bits. carry = bit WIDTH of the raw sum.
REQ-019 Wrap mode: Z = low WIDTH bits of the raw sum. Saturate mode: Z = all-ones when carry is 1, otherwise the low WIDTH bits.
REQ-020 The sum is computed combinationally before stage 1. Stages 2..STAGES only carry results forward.
REQ-021 Each stage holds a valid bit and a payload (Z, carry, sat).
REQ-022 Stage k loads from stage k-1 when stage k is empty or is unloading in the same cycle. The last stage unloads on an output transfer.
REQ-023 Bubbles collapse: an empty stage accepts data even while later stages are stalled.
REQ-024 ready_in = stage 1 empty, OR stage 1 is moving forward this cycle.
REQ-025 ready_in shall not depend combinationally on valid_in. Its combinational path from ready_out is permitted.
REQ-026 Latency, unstalled: a result is valid exactly STAGES cycles after its input transfer.
REQ-027 Throughput: one result per cycle while ready_out stays 1.
REQ-028 Ordering: results leave in acceptance order. No result is dropped or duplicated.
REQ-029 Hold rule: while valid_out=1 and ready_out=0, Z_out, carry_out and sat_out stay stable and valid_out stays 1.
REQ-030 Capacity: the pipeline holds STAGES results. With all stages full and ready_out=0, ready_in=0.
REQ-031 Full pipeline with ready_out=1: an input transfer and an output transfer occur in the same cycle.
REQ-032 count_out increments by 1 on every output transfer.
REQ-033 Payload registers are don't-care while their valid bit is 0. The bench checks payload only when valid_out=1.

Reset
REQ-034 rst_in=1 at a clock edge clears every stage valid bit. Outputs then read valid_out=0, count_out=0, Z_out=0, carry_out=0 and sat_out=0.
REQ-035 ready_in = 1 in the first cycle after reset deasserts.
REQ-036 Reset mid-operation discards all in-flight results. No output transfer occurs in a reset cycle.
REQ-037 Reset has priority over simultaneous input and output transfers.

Structure
REQ-038 Shared package add_pkg holds the mode type (ADD_WRAP=0, ADD_SAT=1) and the payload struct (Z, carry, sat).
REQ-039 One sub-module, pipe_stage, holds a single valid/payload register stage with its load and unload logic. pipe_add_flow instantiates it STAGES times via generate.

Verification
REQ-040 WIDTH=8, STAGES=2, wrap mode, A=200, B=100, ready_out=1 -> exactly 2 cycles later: Z_out=44, carry_out=1, sat_out=0, count_out=1.
REQ-041 SAT_EN=1, mode_in=1, A=200, B=100 -> Z_out=255, carry_out=1, sat_out=1. Same test with A=10, B=20 -> Z_out=30, sat_out=0.
REQ-042 Backpressure: hold ready_out=0 and stream 5 operands -> ready_in drops after 2 acceptances, and Z_out holds the first result stable. Then release ready_out -> results arrive in order, and 5 results exist once the remaining 3 are accepted and drained.
REQ-043 Bubble collapse: one result stalled in the last stage, stage 1 empty -> ready_in=1, and the next input is accepted that cycle.
REQ-044 Reset mid-stream with 2 results in flight -> valid_out=0 and count_out=0 next cycle. A post-reset input yields only its own result.
REQ-045 Random valid_in/ready_out, STAGES=1 and STAGES=4, 10k transfers -> scoreboard matches the reference sum/carry/sat in order, and count_out equals the delivered count mod 65536.

Source files
------------

// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared types for the flow-controlled pipelined adder
//
// Purpose : mode encoding and the per-stage payload carried down the pipeline.
// Ports   : none (package).
package add_pkg;

  // Widest operand the adder supports; payload Z is sized to this and the
  // top uses only the low WIDTH bits.
  localparam int ADD_MAX_WIDTH = 64;

  typedef enum logic {
    ADD_WRAP = 1'b0,
    ADD_SAT  = 1'b1
  } add_mode_e;

  typedef struct packed {
    logic [ADD_MAX_WIDTH-1:0] z;
    logic                     carry;
    logic                     sat;
  } add_payload_t;

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid/payload register stage with ready/valid handshake
//
// Purpose : holds a single result; loads when empty or when unloading this cycle.
// Ports   : clk_in, rst_in          clock, synchronous active-high reset
//           i_valid, i_data, o_ready  upstream side (offer / accept)
//           o_valid, o_data, i_ready  downstream side (offer / accept)
module pipe_stage
  import add_pkg::*;
(
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         i_valid,
  input  add_payload_t i_data,
  output logic         o_ready,
  output logic         o_valid,
  output add_payload_t o_data,
  input  logic         i_ready
);

  logic         r_valid;
  add_payload_t r_data;

  // Accept when empty, or when the held result leaves this same cycle.
  // This is what lets bubbles collapse behind a stalled later stage.
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/pipe_add_flow.sv
// rtl/pipe_add_flow.sv - pipelined unsigned adder with wrap/saturate and ready/valid flow control
//
// Purpose : Z = A + B (wrap or clamp to all-ones), carried through STAGES
//           register stages with full backpressure and bubble collapse.
// Ports   : clk_in, rst_in                  clock, synchronous active-high reset
//           A_in, B_in, mode_in, valid_in   operand offer (mode 0 wrap, 1 saturate)
//           ready_in                        operands accepted this cycle
//           Z_out, carry_out, sat_out       result payload
//           valid_out, ready_out            result offer / downstream accept
//           count_out                       results delivered since reset (wraps)
module pipe_add_flow
  import add_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SAT_EN = 0
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             mode_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [WIDTH-1:0] Z_out,
  output logic             carry_out,
  output logic             sat_out,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [15:0]      count_out
);

  logic [WIDTH:0] w_sum;
  logic           w_sat_mode;
  add_payload_t   w_pay;

  // Stage chain: index k is the input side of stage k, index STAGES is the
  // output port side.
  logic           w_valid [STAGES+1];
  logic           w_ready [STAGES+1];
  add_payload_t   w_data  [STAGES+1];

  logic [15:0]    r_count;

  assign w_sum      = {1'b0, A_in} + {1'b0, B_in};
  assign w_sat_mode = (SAT_EN != 0) && (add_mode_e'(mode_in) == ADD_SAT);

  always_comb begin
    w_pay       = '0;
    w_pay.carry = w_sum[WIDTH];
    w_pay.sat   = w_sat_mode && w_sum[WIDTH];
    if (w_pay.sat) begin
      w_pay.z[WIDTH-1:0] = '1;
    end else begin
      w_pay.z[WIDTH-1:0] = w_sum[WIDTH-1:0];
    end
  end

  assign w_valid[0]      = valid_in;
  assign w_data[0]       = w_pay;
  assign ready_in        = w_ready[0];
  assign w_ready[STAGES] = ready_out;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      pipe_stage u_stage (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_valid (w_valid[k]),
        .i_data  (w_data[k]),
        .o_ready (w_ready[k]),
        .o_valid (w_valid[k+1]),
        .o_data  (w_data[k+1]),
        .i_ready (w_ready[k+1])
      );
    end
  endgenerate

  assign valid_out = w_valid[STAGES];
  assign Z_out     = w_data[STAGES].z[WIDTH-1:0];
  assign carry_out = w_data[STAGES].carry;
  assign sat_out   = w_data[STAGES].sat;
  assign count_out = r_count;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_count <= '0;
    end else if (valid_out && ready_out) begin
      r_count <= r_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_add_flow.sv
// tb/tb_pipe_add_flow.sv - directed bench for pipe_add_flow across three configurations
//
// Purpose : instance 0 WIDTH=8 STAGES=2 SAT_EN=1, instance 1 STAGES=4 SAT_EN=0,
//           instance 2 STAGES=1 SAT_EN=1; shared clock and reset.
module tb_pipe_add_flow;

  logic       clk;
  logic       rst;
  logic [7:0] a_i [3];
  logic [7:0] b_i [3];
  logic       m_i [3];
  logic       vi  [3];
  logic       ri  [3];
  logic [7:0] zo  [3];
  logic       co  [3];
  logic       so  [3];
  logic       vo  [3];
  logic       ro  [3];
  logic [15:0] cnt [3];

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_add_flow #(.WIDTH(8), .STAGES(2), .SAT_EN(1)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .A_in(a_i[0]), .B_in(b_i[0]), .mode_in(m_i[0]),
    .valid_in(vi[0]), .ready_in(ri[0]), .Z_out(zo[0]), .carry_out(co[0]),
    .sat_out(so[0]), .valid_out(vo[0]), .ready_out(ro[0]), .count_out(cnt[0]));

  pipe_add_flow #(.WIDTH(8), .STAGES(4), .SAT_EN(0)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .A_in(a_i[1]), .B_in(b_i[1]), .mode_in(m_i[1]),
    .valid_in(vi[1]), .ready_in(ri[1]), .Z_out(zo[1]), .carry_out(co[1]),
    .sat_out(so[1]), .valid_out(vo[1]), .ready_out(ro[1]), .count_out(cnt[1]));

  pipe_add_flow #(.WIDTH(8), .STAGES(1), .SAT_EN(1)) u_dut2 (
    .clk_in(clk), .rst_in(rst), .A_in(a_i[2]), .B_in(b_i[2]), .mode_in(m_i[2]),
    .valid_in(vi[2]), .ready_in(ri[2]), .Z_out(zo[2]), .carry_out(co[2]),
    .sat_out(so[2]), .valid_out(vo[2]), .ready_out(ro[2]), .count_out(cnt[2]));

  function automatic int stg(input int d);
    case (d)
      0: return 2;
      1: return 4;
      default: return 1;
    endcase
  endfunction

  // Reference: {sat, carry, z}
  function automatic logic [9:0] ref_add(input int d, input logic [7:0] a,
                                         input logic [7:0] b, input logic m);
    logic [8:0] s;
    logic       sat;
    s   = {1'b0, a} + {1'b0, b};
    sat = (d != 1) && m && s[8];
    return {sat, s[8], sat ? 8'hFF : s[7:0]};
  endfunction

  // All tasks start just after a falling edge, which is where inputs are driven.
  task automatic send_one(input int d, input logic [7:0] a, input logic [7:0] b,
                          input logic m, input logic [7:0] ez, input logic ec,
                          input logic es);
    int lat;
    logic [15:0] c0;
    ro[d] = 1'b1; a_i[d] = a; b_i[d] = b; m_i[d] = m; vi[d] = 1'b1;
    #1;
    checks++;
    if (ri[d] !== 1'b1) begin
      errors++; $display("FAIL send_ready d%0d: got %b want 1", d, ri[d]);
    end
    @(negedge clk);
    vi[d] = 1'b0;
    lat = 1;
    while (vo[d] !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != stg(d)) begin
      errors++; $display("FAIL latency d%0d: got %0d want %0d", d, lat, stg(d));
    end
    checks++;
    if ({so[d], co[d], zo[d]} !== {es, ec, ez}) begin
      errors++;
      $display("FAIL payload d%0d: got z=%0d c=%b s=%b want z=%0d c=%b s=%b",
               d, zo[d], co[d], so[d], ez, ec, es);
    end
    c0 = cnt[d];
    @(negedge clk);
    checks++;
    if (cnt[d] !== c0 + 16'd1 || vo[d] !== 1'b0) begin
      errors++;
      $display("FAIL delivered d%0d: got cnt=%0d v=%b want cnt=%0d v=0", d, cnt[d], vo[d], c0 + 16'd1);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      vi[d] = 1'b0; ro[d] = 1'b0; a_i[d] = 8'd0; b_i[d] = 8'd0; m_i[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (vo[d] !== 1'b0 || cnt[d] !== 16'd0 || zo[d] !== 8'd0 || co[d] !== 1'b0 ||
          so[d] !== 1'b0 || ri[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset d%0d: got v=%b cnt=%0d z=%0d c=%b s=%b rdy=%b want 0/0/0/0/0/1",
                 d, vo[d], cnt[d], zo[d], co[d], so[d], ri[d]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    send_one(0, 8'd200, 8'd100, 1'b0, 8'd44, 1'b1, 1'b0);
    checks++;
    if (cnt[0] !== 16'd1) begin
      errors++; $display("FAIL wrap_count: got %0d want 1", cnt[0]);
    end
    send_one(2, 8'd255, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_saturate;
    send_one(0, 8'd200, 8'd100, 1'b1, 8'd255, 1'b1, 1'b1);
    send_one(0, 8'd10, 8'd20, 1'b1, 8'd30, 1'b0, 1'b0);
    send_one(0, 8'd255, 8'd0, 1'b1, 8'd255, 1'b0, 1'b0);
    send_one(2, 8'd255, 8'd1, 1'b1, 8'd255, 1'b1, 1'b1);
    // SAT_EN=0 instance ignores mode_in
    send_one(1, 8'd200, 8'd100, 1'b1, 8'd44, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    logic [7:0] oa [5];
    logic [7:0] ob [5];
    logic [9:0] ex [5];
    int acc;
    int got;
    int cyc;
    logic [15:0] c0;
    oa = '{8'd1, 8'd100, 8'd200, 8'd7, 8'd255};
    ob = '{8'd2, 8'd100, 8'd60, 8'd8, 8'd255};
    ex = '{{2'b00, 8'd3}, {2'b00, 8'd200}, {2'b01, 8'd4}, {2'b00, 8'd15}, {2'b01, 8'd254}};
    c0 = cnt[0];
    acc = 0;
    ro[0] = 1'b0; m_i[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_i[0] = oa[acc]; b_i[0] = ob[acc]; vi[0] = 1'b1;
      #1;
      if (vo[0] === 1'b1) begin
        checks++;
        if (zo[0] !== 8'd3) begin
          errors++; $display("FAIL bp_hold: got %0d want 3", zo[0]);
        end
      end
      if (ri[0] === 1'b1) acc++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (acc != 2 || ri[0] !== 1'b0 || vo[0] !== 1'b1) begin
      errors++; $display("FAIL bp_full: got acc=%0d rdy=%b v=%b want 2/0/1", acc, ri[0], vo[0]);
    end
    ro[0] = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 5 && cyc < 40) begin
      vi[0] = (acc < 5);
      if (acc < 5) begin a_i[0] = oa[acc]; b_i[0] = ob[acc]; end
      #1;
      if (vo[0] === 1'b1) begin
        checks++;
        if ({so[0], co[0], zo[0]} !== ex[got]) begin
          errors++; $display("FAIL bp_order[%0d]: got %h want %h", got, {so[0], co[0], zo[0]}, ex[got]);
        end
        got++;
      end
      if (vi[0] && ri[0] === 1'b1) acc++;
      @(negedge clk);
      cyc++;
    end
    vi[0] = 1'b0;
    checks++;
    if (got != 5 || cnt[0] !== c0 + 16'd5) begin
      errors++; $display("FAIL bp_drain: got n=%0d cnt=%0d want 5 cnt=%0d", got, cnt[0], c0 + 16'd5);
    end
  endtask

  task automatic test_bubble;
    ro[0] = 1'b0; m_i[0] = 1'b0;
    a_i[0] = 8'd9; b_i[0] = 8'd9; vi[0] = 1'b1;
    @(negedge clk);
    vi[0] = 1'b0;
    @(negedge clk);
    a_i[0] = 8'd1; b_i[0] = 8'd1; vi[0] = 1'b1;
    #1;
    checks++;
    if (ri[0] !== 1'b1 || vo[0] !== 1'b1) begin
      errors++; $display("FAIL bubble_ready: got rdy=%b v=%b want 1/1", ri[0], vo[0]);
    end
    @(negedge clk);
    vi[0] = 1'b0;
    #1;
    checks++;
    if (ri[0] !== 1'b0 || zo[0] !== 8'd18) begin
      errors++; $display("FAIL bubble_full: got rdy=%b z=%0d want 0/18", ri[0], zo[0]);
    end
    ro[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (vo[0] !== 1'b1 || zo[0] !== 8'd2) begin
      errors++; $display("FAIL bubble_second: got v=%b z=%0d want 1/2", vo[0], zo[0]);
    end
    @(negedge clk);
    checks++;
    if (vo[0] !== 1'b0) begin
      errors++; $display("FAIL bubble_empty: got v=%b want 0", vo[0]);
    end
  endtask

  task automatic test_mid_reset;
    ro[0] = 1'b0; m_i[0] = 1'b0;
    a_i[0] = 8'd50; b_i[0] = 8'd50; vi[0] = 1'b1;
    @(negedge clk);
    a_i[0] = 8'd60; b_i[0] = 8'd60;
    @(negedge clk);
    rst = 1'b1; ro[0] = 1'b1; a_i[0] = 8'd70; b_i[0] = 8'd70;
    @(negedge clk);
    rst = 1'b0; vi[0] = 1'b0; ro[0] = 1'b0;
    #1;
    checks++;
    if (vo[0] !== 1'b0 || cnt[0] !== 16'd0 || ri[0] !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got v=%b cnt=%0d rdy=%b want 0/0/1", vo[0], cnt[0], ri[0]);
    end
    @(negedge clk);
    send_one(0, 8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (vo[0] !== 1'b0 || cnt[0] !== 16'd1) begin
        errors++; $display("FAIL post_reset_extra: got v=%b cnt=%0d want 0/1", vo[0], cnt[0]);
      end
    end
  endtask

  task automatic test_stream(input int d, input int n);
    logic [9:0] q[$];
    logic [9:0] e;
    logic [7:0] pa;
    logic [7:0] pb;
    logic       pm;
    bit         have;
    int sent;
    int got;
    int cyc;
    have = 0; sent = 0; got = 0; cyc = 0;
    pa = 8'd0; pb = 8'd0; pm = 1'b0;
    while (got < n && cyc < 45000) begin
      if (!have) begin
        pa = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
        pb = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
        pm = 1'($urandom);
        have = 1;
      end
      a_i[d] = pa; b_i[d] = pb; m_i[d] = pm;
      vi[d] = (sent < n) && ($urandom_range(3) != 0);
      ro[d] = ($urandom_range(3) != 0);
      #1;
      if (vo[d] === 1'b1 && ro[d]) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra d%0d: got z=%0d want none", d, zo[d]);
        end else begin
          e = q.pop_front();
          if ({so[d], co[d], zo[d]} !== e) begin
            errors++;
            $display("FAIL stream d%0d #%0d: got %h want %h", d, got, {so[d], co[d], zo[d]}, e);
          end
        end
        got++;
      end
      if (vi[d] && ri[d] === 1'b1) begin
        q.push_back(ref_add(d, pa, pb, pm));
        sent++;
        have = 0;
      end
      @(negedge clk);
      cyc++;
    end
    vi[d] = 1'b0;
    ro[d] = 1'b1;
    checks++;
    if (got != n || cnt[d] !== 16'(n)) begin
      errors++; $display("FAIL stream_count d%0d: got n=%0d cnt=%0d want %0d", d, got, cnt[d], n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      vi[d] = 1'b0; ro[d] = 1'b0; a_i[d] = 8'd0; b_i[d] = 8'd0; m_i[d] = 1'b0;
    end
    @(negedge clk);
    test_reset();
    test_wrap();
    test_saturate();
    test_backpressure();
    test_bubble();
    test_mid_reset();
    test_stream(1, 10000);
    test_stream(2, 10000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
